// File: rtl/mem_wb_stage_pkg.sv
// Shared op codes and stall-vector indices for the MEM/WB stage.
package mem_wb_stage_pkg;

  localparam int ALUOP_W = 8;

  // Op codes as used by the EX/MEM stages of the core.
  localparam logic [ALUOP_W-1:0] EXE_NOP_OP = 8'b0000_0000;
  localparam logic [ALUOP_W-1:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [ALUOP_W-1:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [ALUOP_W-1:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [ALUOP_W-1:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [ALUOP_W-1:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [ALUOP_W-1:0] EXE_LWL_OP = 8'b1110_0010;
  localparam logic [ALUOP_W-1:0] EXE_LWR_OP = 8'b1110_0110;

  // Stall vector bit positions.
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Combinational load formatter: big-endian lane select, extension and LWL/LWR merge.
module mem_wb_stage_load_align
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [ALUOP_W-1:0] aluop,
  input  logic [1:0]         addr_lo,
  input  logic [DATA_W-1:0]  word,
  input  logic [DATA_W-1:0]  reg2,
  input  logic [DATA_W-1:0]  alu_wdata,
  output logic [DATA_W-1:0]  result
);

  function automatic logic signed [DATA_W-1:0] sext8(input logic signed [7:0] v);
    sext8 = v;
  endfunction

  function automatic logic signed [DATA_W-1:0] sext16(input logic signed [15:0] v);
    sext16 = v;
  endfunction

  logic [4:0]        sh_l;     // 8*n: LWL left shift
  logic [4:0]        sh_r;     // 24-8n: LWR right shift, also byte-lane shift
  logic [DATA_W-1:0] ones;
  logic [DATA_W-1:0] lane;     // addressed byte moved to [7:0]
  logic [15:0]       half;

  assign sh_l = {addr_lo, 3'b000};
  assign sh_r = {~addr_lo, 3'b000};
  assign ones = '1;
  assign lane = word >> sh_r;
  assign half = addr_lo[1] ? word[15:0] : word[31:16];

  // Select the formatted write-back value for the stored op.
  always_comb begin
    result = alu_wdata;
    case (aluop)
      EXE_LB_OP:  result = sext8(lane[7:0]);
      EXE_LBU_OP: result = {{(DATA_W-8){1'b0}}, lane[7:0]};
      EXE_LH_OP:  result = addr_lo[0] ? '0 : sext16(half);
      EXE_LHU_OP: result = addr_lo[0] ? '0 : {{(DATA_W-16){1'b0}}, half};
      EXE_LW_OP:  result = word;
      EXE_LWL_OP: result = (word << sh_l) | (reg2 & ~(ones << sh_l));
      EXE_LWR_OP: result = (reg2 & ~(ones >> sh_r)) | (word >> sh_r);
      default:    result = alu_wdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with synchronous-memory load data capture and formatting.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         stall,
  input  logic               flush,
  input  logic [RADDR_W-1:0] mem_wd,
  input  logic               mem_wreg,
  input  logic [DATA_W-1:0]  mem_wdata,
  input  logic [ALUOP_W-1:0] mem_aluop,
  input  logic [1:0]         mem_addr_lo,
  input  logic [DATA_W-1:0]  mem_reg2,
  input  logic               mem_whilo,
  input  logic [DATA_W-1:0]  mem_hi,
  input  logic [DATA_W-1:0]  mem_lo,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic               wb_we,
  output logic [RADDR_W-1:0] wb_waddr,
  output logic [DATA_W-1:0]  wb_wdata,
  output logic               wb_whilo,
  output logic [DATA_W-1:0]  wb_hi,
  output logic [DATA_W-1:0]  wb_lo
);

  logic [RADDR_W-1:0] wd_p1;
  logic               wreg_p1;
  logic [DATA_W-1:0]  wdata_p1;
  logic [ALUOP_W-1:0] aluop_p1;
  logic [1:0]         addr_lo_p1;
  logic [DATA_W-1:0]  reg2_p1;
  logic               whilo_p1;
  logic [DATA_W-1:0]  hi_p1;
  logic [DATA_W-1:0]  lo_p1;
  logic [DATA_W-1:0]  hold_p1;
  logic               held_p1;

  logic bubble;
  logic capture;
  logic [DATA_W-1:0] load_word;

  // Flush beats everything; a MEM stall with WB free drains the stage.
  assign bubble  = flush | (stall[STALL_MEM] & ~stall[STALL_WB]);
  assign capture = ~bubble & ~stall[STALL_MEM];

  // ---- MEM -> WB stage boundary ----
  // Stage register: bubble, capture or hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_p1      <= '0;
      wreg_p1    <= 1'b0;
      wdata_p1   <= '0;
      aluop_p1   <= EXE_NOP_OP;
      addr_lo_p1 <= '0;
      reg2_p1    <= '0;
      whilo_p1   <= 1'b0;
      hi_p1      <= '0;
      lo_p1      <= '0;
    end else if (bubble) begin
      wd_p1      <= '0;
      wreg_p1    <= 1'b0;
      wdata_p1   <= '0;
      aluop_p1   <= EXE_NOP_OP;
      addr_lo_p1 <= '0;
      reg2_p1    <= '0;
      whilo_p1   <= 1'b0;
      hi_p1      <= '0;
      lo_p1      <= '0;
    end else if (capture) begin
      wd_p1      <= mem_wd;
      wreg_p1    <= mem_wreg;
      wdata_p1   <= mem_wdata;
      aluop_p1   <= mem_aluop;
      addr_lo_p1 <= mem_addr_lo;
      reg2_p1    <= mem_reg2;
      whilo_p1   <= mem_whilo;
      hi_p1      <= mem_hi;
      lo_p1      <= mem_lo;
    end
  end

  // Memory read data is only presented for one cycle; keep it while WB is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_p1 <= '0;
      held_p1 <= 1'b0;
    end else if (bubble || capture) begin
      held_p1 <= 1'b0;
    end else if (!held_p1) begin
      hold_p1 <= dmem_rdata;
      held_p1 <= 1'b1;
    end
  end

  assign load_word = held_p1 ? hold_p1 : dmem_rdata;

  mem_wb_stage_load_align #(
    .DATA_W(DATA_W)
  ) u_align (
    .aluop     (aluop_p1),
    .addr_lo   (addr_lo_p1),
    .word      (load_word),
    .reg2      (reg2_p1),
    .alu_wdata (wdata_p1),
    .result    (wb_wdata)
  );

  assign wb_we    = wreg_p1;
  assign wb_waddr = wd_p1;
  assign wb_whilo = whilo_p1;
  assign wb_hi    = hi_p1;
  assign wb_lo    = lo_p1;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed scoreboard bench for mem_wb_stage.
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
  } out_t;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_aluop;
  logic [1:0]  mem_addr_lo;
  logic [31:0] mem_reg2;
  logic        mem_whilo;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic [31:0] dmem_rdata;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        wb_whilo;
  logic [31:0] wb_hi;
  logic [31:0] wb_lo;

  out_t sb_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  mem_wb_stage #(.DATA_W(32), .RADDR_W(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_aluop(mem_aluop), .mem_addr_lo(mem_addr_lo), .mem_reg2(mem_reg2),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .dmem_rdata(dmem_rdata),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_exp(input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                          input logic whilo, input logic [31:0] hi, input logic [31:0] lo);
    out_t e;
    e = {we, waddr, wdata, whilo, hi, lo};
    sb_q.push_back(e);
  endtask

  task automatic check_sb(input string tag);
    out_t obs;
    out_t exp;
    obs = {wb_we, wb_waddr, wb_wdata, wb_whilo, wb_hi, wb_lo};
    n_total++;
    if (sb_q.size() == 0) begin
      $error("FAIL %s scoreboard empty, observed=%h", tag, obs);
    end else begin
      exp = sb_q.pop_front();
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one MEM-stage entry at the falling edge with stall/flush released.
  task automatic issue(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                       input logic [7:0] op, input logic [1:0] off, input logic [31:0] reg2,
                       input logic whilo, input logic [31:0] hi, input logic [31:0] lo);
    @(negedge clk);
    mem_wd = wd; mem_wreg = wreg; mem_wdata = wdata; mem_aluop = op;
    mem_addr_lo = off; mem_reg2 = reg2; mem_whilo = whilo; mem_hi = hi; mem_lo = lo;
    stall = 6'b0; flush = 1'b0;
  endtask

  // Capture edge, then present memory data for the first WB cycle.
  task automatic wb_cycle(input logic [31:0] dmem);
    @(posedge clk);
    #1 dmem_rdata = dmem;
    #1;
  endtask

  task automatic load(input string tag, input logic [7:0] op, input logic [1:0] off,
                      input logic [31:0] reg2, input logic [31:0] dmem, input logic [31:0] exp);
    issue(5'd3, 1'b1, 32'h0, op, off, reg2, 1'b0, 32'h0, 32'h0);
    push_exp(1'b1, 5'd3, exp, 1'b0, 32'h0, 32'h0);
    wb_cycle(dmem);
    check_sb(tag);
  endtask

  initial begin
    rst = 1'b1; stall = 6'b0; flush = 1'b0;
    mem_wd = '0; mem_wreg = 1'b0; mem_wdata = '0; mem_aluop = EXE_NOP_OP;
    mem_addr_lo = '0; mem_reg2 = '0; mem_whilo = 1'b0; mem_hi = '0; mem_lo = '0;
    dmem_rdata = '0;

    #2;
    push_exp(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    check_sb("reset_init");
    @(negedge clk);
    rst = 1'b0;

    // Plain ALU result with HI/LO write.
    issue(5'd5, 1'b1, 32'h12345678, 8'h21, 2'd0, 32'h0, 1'b1, 32'hA5A5A5A5, 32'h5A5A5A5A);
    push_exp(1'b1, 5'd5, 32'h12345678, 1'b1, 32'hA5A5A5A5, 32'h5A5A5A5A);
    wb_cycle(32'hFFFFFFFF);
    check_sb("alu_op");

    load("lb_off0",  EXE_LB_OP,  2'd0, 32'h0, 32'h80FF7F01, 32'hFFFFFF80);
    load("lbu_off1", EXE_LBU_OP, 2'd1, 32'h0, 32'h80FF7F01, 32'h000000FF);
    load("lb_off3",  EXE_LB_OP,  2'd3, 32'h0, 32'h80FF7F01, 32'h00000001);
    load("lh_off2",  EXE_LH_OP,  2'd2, 32'h0, 32'h80FF7F01, 32'h00007F01);
    load("lh_off0",  EXE_LH_OP,  2'd0, 32'h0, 32'h80FF7F01, 32'hFFFF80FF);
    load("lhu_off0", EXE_LHU_OP, 2'd0, 32'h0, 32'h80FF7F01, 32'h000080FF);
    load("lh_odd",   EXE_LH_OP,  2'd1, 32'h0, 32'h80FF7F01, 32'h00000000);
    load("lwl_off1", EXE_LWL_OP, 2'd1, 32'h11223344, 32'hAABBCCDD, 32'hBBCCDD44);
    load("lwl_off3", EXE_LWL_OP, 2'd3, 32'h11223344, 32'hAABBCCDD, 32'hDD223344);
    load("lwr_off1", EXE_LWR_OP, 2'd1, 32'h11223344, 32'hAABBCCDD, 32'h1122AABB);
    load("lwr_off0", EXE_LWR_OP, 2'd0, 32'h11223344, 32'hAABBCCDD, 32'h112233AA);
    load("lw",       EXE_LW_OP,  2'd0, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF);

    // WB stall over three cycles: memory word must be held from the first cycle.
    issue(5'd7, 1'b1, 32'h0, EXE_LW_OP, 2'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    push_exp(1'b1, 5'd7, 32'hCAFEF00D, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1 dmem_rdata = 32'hCAFEF00D; stall = 6'b111111;
    mem_wd = 5'd1; mem_wdata = 32'h99999999; mem_aluop = 8'h21;
    #1 check_sb("wbstall_c1");
    push_exp(1'b1, 5'd7, 32'hCAFEF00D, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1 dmem_rdata = 32'h00000000;
    #1 check_sb("wbstall_c2");
    push_exp(1'b1, 5'd7, 32'hCAFEF00D, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1 dmem_rdata = 32'h55555555;
    #1 check_sb("wbstall_c3");

    // MEM stalled with WB free drains the stage.
    issue(5'd9, 1'b1, 32'hAAAA0001, 8'h21, 2'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    push_exp(1'b1, 5'd9, 32'hAAAA0001, 1'b0, 32'h0, 32'h0);
    wb_cycle(32'h0);
    check_sb("pre_bubble");
    @(negedge clk);
    stall = 6'b010000; mem_wd = 5'd10;
    push_exp(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #2 check_sb("stall4_bubble");

    // Flush wins over a full stall.
    issue(5'd11, 1'b1, 32'hBBBB0002, 8'h21, 2'd0, 32'h0, 1'b1, 32'h1, 32'h2);
    push_exp(1'b1, 5'd11, 32'hBBBB0002, 1'b1, 32'h1, 32'h2);
    wb_cycle(32'h0);
    check_sb("pre_flush");
    @(negedge clk);
    flush = 1'b1; stall = 6'b111111;
    push_exp(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #2 check_sb("flush_with_stall");

    // Full stall holds the stage contents.
    issue(5'd12, 1'b1, 32'h0BADCAFE, 8'h21, 2'd0, 32'h0, 1'b1, 32'h3, 32'h4);
    push_exp(1'b1, 5'd12, 32'h0BADCAFE, 1'b1, 32'h3, 32'h4);
    wb_cycle(32'h0);
    check_sb("pre_hold");
    @(negedge clk);
    stall = 6'b111111; mem_wd = 5'd13; mem_wdata = 32'h0; mem_whilo = 1'b0;
    push_exp(1'b1, 5'd12, 32'h0BADCAFE, 1'b1, 32'h3, 32'h4);
    @(posedge clk);
    #2 check_sb("stall_all_hold");

    // Asynchronous reset in the middle of a held load.
    issue(5'd14, 1'b1, 32'h0, EXE_LW_OP, 2'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1 dmem_rdata = 32'h12345678; stall = 6'b111111;
    @(posedge clk);
    #1 dmem_rdata = 32'h0;
    #2 rst = 1'b1;
    #1;
    push_exp(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    check_sb("rst_midload");
    @(negedge clk);
    rst = 1'b0; stall = 6'b0;

    load("lw_after_rst", EXE_LW_OP, 2'd0, 32'h0, 32'h0F0F1234, 32'h0F0F1234);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
